// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges 256-bit cacheline requests onto a 4-beat, 64-bit burst memory port
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [LINE_WIDTH-1:0] line;
  logic busy, last;
  assign busy = state == READ || state == WRITE;
  assign last = busy && resp_i && cnt == CW'(BEATS - 1);
  assign read_o = state == READ;
  assign write_o = state == WRITE;
  assign resp_o = state == DONE;
  assign burst_o = write_o ? line[cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // A simultaneous read and write takes the write: the dirty victim must leave before the fill lands.
  always_comb begin
    state_nxt = state == IDLE ? (write_i ? WRITE : read_i ? READ : IDLE) :
                state == DONE ? IDLE : last ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      line      <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (write_i) line <= line_i;
      if (write_i || read_i) address_o <= address_i & ~32'(LINE_WIDTH / 8 - 1);
    end else if (busy && resp_i) begin
      cnt <= cnt + 1'b1;
      if (read_o) line[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
      if (read_o && last) line_o <= {burst_i, line[LINE_WIDTH-BURST_WIDTH-1:0]};
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed vector table plus random traffic against a shadow-memory model
module tb_cacheline_adaptor;
  logic clk = 0, rst = 1;
  logic [255:0] line_i = '0, line_o;
  logic [31:0] address_i = '0, address_o;
  logic read_i = 0, write_i = 0, resp_o, read_o, write_o, resp_i = 0;
  logic [63:0] burst_i = '0, burst_o;
  int total = 0, bad = 0, pulses = 0, exp_pulses = 0;
  logic [255:0] last_line = '0;
  logic [255:0] mem [logic [26:0]];

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (resp_o) pulses++;

  typedef struct {
    logic rd, wr;
    logic [31:0] addr;
    logic [255:0] data;
    logic [15:0] pat;
    logic stray;
    logic [255:0] exp_line;
  } vec_t;

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] data,
                     input logic [15:0] pat, input logic stray, input logic [255:0] exp_line);
    int beat, cyc, pi;
    read_i = rd; write_i = wr; address_i = addr; line_i = data;
    @(negedge clk);
    read_i = 0; write_i = 0; address_i = $urandom; line_i = '0;
    chk("addr_o", address_o, {addr[31:5], 5'b0});
    chk("read_o", read_o, !wr && rd);
    chk("write_o", write_o, wr);
    beat = 0; pi = 0; cyc = 0;
    while (beat < 4 && cyc < 40) begin
      resp_i = pi < 16 ? pat[pi] : 1'b1;
      pi++;
      if (resp_i) begin
        if (wr) chk("burst_o", burst_o, data[beat*64 +: 64]);
        else burst_i = data[beat*64 +: 64];
        beat++;
      end
      @(negedge clk);
      cyc++;
      burst_i = {$urandom, $urandom};
      if (beat < 4) begin
        chk("busy", read_o | write_o, 1);
        chk("resp_early", resp_o, 0);
        chk("addr_hold", address_o, {addr[31:5], 5'b0});
      end
    end
    if (beat < 4) chk("timeout_beats", beat, 4);
    resp_i = stray;
    exp_pulses++;
    chk("resp_o", resp_o, 1);
    chk("req_in_done", read_o | write_o, 0);
    chk("line_o", line_o, exp_line);
    @(negedge clk);
    resp_i = 0;
    chk("resp_pulse", resp_o, 0);
    chk("idle_req", read_o | write_o, 0);
    chk("burst_idle", burst_o, 0);
    chk("line_hold", line_o, exp_line);
  endtask

  vec_t vecs [5];

  initial begin
    logic [255:0] d, e;
    logic [26:0] idx;
    logic w;
    vecs[0] = '{1, 0, 32'h0000_1234,
      {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
      16'hffff, 0,
      {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}};
    vecs[1] = '{0, 1, 32'hABCD_EF1F,
      {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA},
      16'hffff, 1,
      {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}};
    vecs[2] = '{1, 0, 32'h8000_0040,
      {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5555AAAA5555AAAA, 64'hDEADBEEFCAFEF00D},
      16'h0059, 1,
      {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5555AAAA5555AAAA, 64'hDEADBEEFCAFEF00D}};
    vecs[3] = '{1, 1, 32'h0000_2000,
      {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'h1234123412341234, 64'h9876987698769876},
      16'h0035, 0,
      {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5555AAAA5555AAAA, 64'hDEADBEEFCAFEF00D}};
    vecs[4] = '{1, 0, 32'h0000_201C,
      {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'h1234123412341234, 64'h9876987698769876},
      16'hffff, 0,
      {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'h1234123412341234, 64'h9876987698769876}};

    @(negedge clk);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_addr_o", address_o, 0);
    chk("rst_line_o", line_o, 0);
    chk("rst_burst_o", burst_o, 0);
    rst = 0;

    resp_i = 1;
    repeat (3) @(negedge clk);
    resp_i = 0;
    chk("stray_idle_req", read_o | write_o, 0);
    chk("stray_idle_resp", resp_o, 0);

    for (int i = 0; i < 5; i++) txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                                    vecs[i].pat, vecs[i].stray, vecs[i].exp_line);

    read_i = 1; address_i = 32'h0000_3000;
    @(negedge clk);
    read_i = 0;
    resp_i = 1; burst_i = 64'h1;
    repeat (2) @(negedge clk);
    resp_i = 0;
    rst = 1;
    #1;
    chk("abort_read_o", read_o, 0);
    chk("abort_resp_o", resp_o, 0);
    chk("abort_addr_o", address_o, 0);
    chk("abort_line_o", line_o, 0);
    @(negedge clk);
    rst = 0;
    last_line = vecs[0].data;
    txn(1, 0, 32'h0000_3000, last_line, 16'hffff, 0, last_line);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      idx = 27'($urandom_range(0, 3));
      w = $urandom_range(0, 1) == 1;
      if (w) mem[idx] = d;
      else if (mem.exists(idx)) d = mem[idx];
      else mem[idx] = d;
      if (!w) last_line = d;
      e = last_line;
      txn(!w || $urandom_range(0, 1) == 1, w, {idx, 5'($urandom)}, d,
          16'($urandom), 1'($urandom), e);
    end

    chk("resp_pulse_count", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
